// File: rtl/bool_window_eval.sv
// bool_window_eval: multi-channel boolean window evaluator.
// Collects DEPTH accepted samples of WIDTH boolean channels. Each channel is
// reduced with AND/OR (optionally NAND/NOR). Once per window it reports the
// per-channel result word and the all-true / any-true summaries.
// Build option: define BOOL_EVAL_INVERT_EN to support the NAND/NOR ops.
// Without it, op[1] is ignored and no output inversion logic is built.
module bool_window_eval #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_flags,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result,
    output logic             all_true,
    output logic             any_true
);

    // The counter must be able to hold DEPTH itself, because it saturates there.
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    // Reduction kind latched at window open: 0 = AND family, 1 = OR family.
    logic             r_op_or;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;

    logic             r_busy;
    logic             r_result_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_all_true;
    logic             r_any_true;

    logic [WIDTH-1:0] w_acc_init;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_final;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_start_ok;
    logic             w_sample_ok;
    logic             w_last;

    // clear outranks both start and in_valid in the same cycle.
    assign w_start_ok  = (r_state == ST_IDLE)  && start    && !clear;
    assign w_sample_ok = (r_state == ST_ACCUM) && in_valid && !clear;
    assign w_last      = w_sample_ok && (r_cnt == CNT_LAST);

    // Saturating sample counter; it never wraps past DEPTH.
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_ONE);

    // Per-channel accumulator update and the window-open seed value.
    // An AND window starts all-ones, and an OR window starts all-zeros.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            assign w_acc_init[gi] = ~op[0];
            assign w_acc_next[gi] = r_op_or ? (r_acc[gi] | in_flags[gi])
                                            : (r_acc[gi] & in_flags[gi]);
        end
    endgenerate

`ifdef BOOL_EVAL_INVERT_EN
    // NAND/NOR: the inversion flag is captured with the op at window open.
    logic r_op_inv;

    // Inversion flag register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op_inv <= 1'b0;
        end else if (w_start_ok) begin
            r_op_inv <= op[1];
        end
    end

    assign w_final = r_op_inv ? ~w_acc_next : w_acc_next;
`else
    // Only AND/OR are supported, so op[1] has no effect.
    logic w_unused_op_hi;
    assign w_unused_op_hi = op[1];
    assign w_final        = w_acc_next;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. DONE always lasts exactly one cycle.
    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_next = ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (w_last) begin
                        w_state_next = ST_DONE;
                    end
                end
                ST_DONE: begin
                    w_state_next = ST_IDLE;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Window datapath: latch the op, then seed and fold the accumulator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op_or <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (w_start_ok) begin
            r_op_or <= op[0];
            r_acc   <= w_acc_init;
            r_cnt   <= '0;
        end else if (w_sample_ok) begin
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_inc;
        end
    end

    // Registered outputs.
    // The result is captured on the edge that takes the last sample, so it
    // appears together with the DONE pulse. It then holds until the next window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_result       <= '0;
            r_all_true     <= 1'b0;
            r_any_true     <= 1'b0;
        end else begin
            r_busy         <= (w_state_next == ST_ACCUM);
            r_result_valid <= (w_state_next == ST_DONE);
            if (w_last) begin
                r_result   <= w_final;
                r_all_true <= &w_final;
                r_any_true <= |w_final;
            end
        end
    end

    assign busy         = r_busy;
    assign result_valid = r_result_valid;
    assign result       = r_result;
    assign all_true     = r_all_true;
    assign any_true     = r_any_true;

endmodule

// File: tb/tb_bool_window_eval.sv
// tb_bool_window_eval: scoreboard bench for bool_window_eval.
// Instance A uses WIDTH=8 and DEPTH=4. Instance B uses WIDTH=1 and DEPTH=1.
// Drivers queue the expected results, and negedge monitors compare each pulse
// against them. The monitors also check the output hold and reset behaviour.
`timescale 1ns/1ps
module tb_bool_window_eval;
    localparam int W = 8;
    localparam int D = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         a_start, a_clear, a_valid;
    logic [1:0]   a_op;
    logic [W-1:0] a_flags;
    logic         a_busy, a_rv, a_all, a_any;
    logic [W-1:0] a_res;

    logic         b_start, b_clear, b_valid;
    logic [1:0]   b_op;
    logic [0:0]   b_flags;
    logic         b_busy, b_rv, b_all, b_any;
    logic [0:0]   b_res;

    bool_window_eval #(.WIDTH(W), .DEPTH(D)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .op(a_op), .clear(a_clear),
        .in_valid(a_valid), .in_flags(a_flags), .busy(a_busy),
        .result_valid(a_rv), .result(a_res), .all_true(a_all), .any_true(a_any)
    );

    bool_window_eval #(.WIDTH(1), .DEPTH(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .op(b_op), .clear(b_clear),
        .in_valid(b_valid), .in_flags(b_flags), .busy(b_busy),
        .result_valid(b_rv), .result(b_res), .all_true(b_all), .any_true(b_any)
    );

    typedef struct packed {
        logic [63:0] res;
        logic        all_t;
        logic        any_t;
        int          at;
    } exp_t;

    exp_t         sb_a[$];
    exp_t         sb_b[$];
    logic [W-1:0] win_q[$];
    logic [W-1:0] dir_q[$];
    bit           vpat_q[$];

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic rst_q    = 1'b0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Reference: a channel's AND is "true in every sample" and its OR is
    // "true in some sample". NAND/NOR negate these when the option is built.
    function automatic logic [W-1:0] model_result(input logic [1:0] o);
        logic [W-1:0] r;
        bit every;
        bit some;
        r = '0;
        for (int ch = 0; ch < W; ch++) begin
            every = 1'b1;
            some  = 1'b0;
            foreach (win_q[k]) begin
                every = every & win_q[k][ch];
                some  = some  | win_q[k][ch];
            end
            r[ch] = o[0] ? some : every;
        end
`ifdef BOOL_EVAL_INVERT_EN
        if (o[1]) r = ~r;
`endif
        return r;
    endfunction

    // Monitor A: check reset values, pulse contents and timing, and output hold.
    logic [W-1:0] a_held     = '0;
    logic         a_held_all = 1'b0;
    logic         a_held_any = 1'b0;
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (!rst_q) begin
            chk("a_reset_busy", a_busy, 0);
            chk("a_reset_rv", a_rv, 0);
            chk("a_reset_result", a_res, 0);
            chk("a_reset_all", a_all, 0);
            chk("a_reset_any", a_any, 0);
            a_held = '0; a_held_all = 1'b0; a_held_any = 1'b0;
        end else if (a_rv) begin
            if (sb_a.size() == 0) begin
                chk("a_unexpected_pulse", a_rv, 0);
            end else begin
                e = sb_a.pop_front();
                $display("A window: result=%02h all=%0b any=%0b cycle=%0d", a_res, a_all, a_any, cyc);
                chk("a_pulse_cycle", cyc, e.at);
                chk("a_result", a_res, e.res);
                chk("a_all_true", a_all, e.all_t);
                chk("a_any_true", a_any, e.any_t);
            end
            a_held = a_res; a_held_all = a_all; a_held_any = a_any;
        end else begin
            chk("a_hold_result", a_res, a_held);
            chk("a_hold_all", a_all, a_held_all);
            chk("a_hold_any", a_any, a_held_any);
        end
    end

    // Monitor B: same checks for the single-channel, single-sample instance.
    logic b_held = 1'b0;
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (!rst_q) begin
            chk("b_reset_result", b_res, 0);
            chk("b_reset_rv", b_rv, 0);
            chk("b_reset_busy", b_busy, 0);
            b_held = 1'b0;
        end else if (b_rv) begin
            if (sb_b.size() == 0) begin
                chk("b_unexpected_pulse", b_rv, 0);
            end else begin
                e = sb_b.pop_front();
                $display("B window: result=%0b all=%0b any=%0b cycle=%0d", b_res, b_all, b_any, cyc);
                chk("b_pulse_cycle", cyc, e.at);
                chk("b_result", b_res, e.res);
                chk("b_all_true", b_all, e.all_t);
                chk("b_any_true", b_any, e.any_t);
            end
            b_held = b_res[0];
        end else begin
            chk("b_hold_result", b_res, b_held);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one full window on instance A.
    // Directed flags come from dir_q and directed valid patterns from vpat_q.
    // Otherwise the stimulus is random. When noise is set, start pulses and op
    // changes are also mixed in where they must be ignored.
    task automatic run_a(input logic [1:0] o, input bit noise);
        int           n;
        int           guard;
        bit           v;
        logic [W-1:0] r;
        exp_t         e;
        n = 0;
        guard = 0;
        win_q.delete();
        a_start = 1'b1;
        a_op    = o;
        a_clear = 1'b0;
        a_valid = noise ? 1'($urandom) : 1'b0;
        a_flags = W'($urandom);
        tick();
        a_start = 1'b0;
        while (n < D && guard < 200) begin
            chk("a_busy_accum", a_busy, 1);
            a_op    = 2'($urandom);
            a_start = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (vpat_q.size() != 0) v = vpat_q.pop_front();
            else                    v = noise ? 1'($urandom) : 1'b1;
            a_valid = v;
            a_flags = (v && dir_q.size() != 0) ? dir_q.pop_front() : W'($urandom);
            if (v) begin
                win_q.push_back(a_flags);
                n++;
                if (n == D) begin
                    r       = model_result(o);
                    e.res   = 64'(r);
                    e.all_t = &r;
                    e.any_t = |r;
                    e.at    = cyc + 1;
                    sb_a.push_back(e);
                end
            end
            tick();
            guard++;
        end
        if (n < D) chk("a_window_guard", n, D);
        a_start = noise ? 1'($urandom) : 1'b0;
        a_valid = noise ? 1'($urandom) : 1'b0;
        a_flags = W'($urandom);
        chk("a_busy_done", a_busy, 0);
        tick();
        a_start = 1'b0;
        a_valid = 1'b0;
    endtask

    // One DEPTH=1 window on instance B. in_valid stays high the whole time.
    // The flag is opposite to the real sample in IDLE and DONE, so any sample
    // taken in the wrong state would corrupt the result.
    task automatic run_b(input logic [1:0] o, input bit s);
        exp_t e;
        logic r;
        b_start = 1'b1;
        b_op    = o;
        b_valid = 1'b1;
        b_flags = ~s;
        tick();
        b_start = 1'b0;
        b_op    = 2'($urandom);
        b_flags = s;
        r = s;
`ifdef BOOL_EVAL_INVERT_EN
        if (o[1]) r = ~r;
`endif
        e.res   = 64'(r);
        e.all_t = r;
        e.any_t = r;
        e.at    = cyc + 1;
        sb_b.push_back(e);
        chk("b_busy_accum", b_busy, 1);
        tick();
        b_flags = ~s;
        chk("b_busy_done", b_busy, 0);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        a_start = 1'b0; a_clear = 1'b0; a_valid = 1'b0; a_op = 2'b00; a_flags = '0;
        b_start = 1'b0; b_clear = 1'b0; b_valid = 1'b0; b_op = 2'b00; b_flags = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // AND over FF, F0, 3C, 30 gives 30.
        dir_q = '{8'hFF, 8'hF0, 8'h3C, 8'h30};
        run_a(2'b00, 1'b0);

        // OR with valid gaps: valid on cycles 1, 3, 4 and 7 after start. Gives 87.
        dir_q  = '{8'h01, 8'h02, 8'h04, 8'h80};
        vpat_q = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        run_a(2'b01, 1'b0);

        // NAND over FF x4: 00 with the option built, FF without it.
        dir_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_a(2'b10, 1'b0);

        // Abort after 2 of 4 samples. Start and in_valid are also high in the
        // clear cycle, and clear must win over both.
        a_start = 1'b1; a_op = 2'b00;
        tick();
        a_start = 1'b0; a_valid = 1'b1; a_flags = W'($urandom);
        tick();
        a_flags = W'($urandom);
        tick();
        a_clear = 1'b1; a_start = 1'b1; a_op = 2'b01; a_flags = W'($urandom);
        tick();
        a_clear = 1'b0; a_start = 1'b0;
        chk("a_busy_after_clear", a_busy, 0);
        tick();
        chk("a_busy_idle_after_clear", a_busy, 0);
        a_valid = 1'b0;

        // Start and clear together in IDLE: the block stays idle.
        a_start = 1'b1; a_clear = 1'b1;
        tick();
        a_start = 1'b0; a_clear = 1'b0;
        chk("a_busy_start_clear", a_busy, 0);
        tick();

        // AND window with ignored start pulses and op changes mid-window.
        run_a(2'b00, 1'b1);

        // Reset in the middle of a window discards it without a pulse.
        a_start = 1'b1; a_op = 2'b01;
        tick();
        a_start = 1'b0; a_valid = 1'b1; a_flags = W'($urandom);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("a_rst_mid_busy", a_busy, 0);
        chk("a_rst_mid_result", a_res, 0);
        rst_n = 1'b1; a_valid = 1'b0;
        tick();

        // Random back-to-back windows.
        for (int i = 0; i < 30; i++) begin
            run_a(2'($urandom), 1'b1);
        end

        // DEPTH=1 windows: true then false, back to back, plus an OR pair.
        run_b(2'b00, 1'b1);
        run_b(2'b00, 1'b0);
        run_b(2'b01, 1'b1);
        run_b(2'b01, 1'b0);
        for (int i = 0; i < 8; i++) begin
            run_b(2'($urandom), 1'($urandom));
        end
        b_valid = 1'b0;

        repeat (4) tick();
        chk("a_scoreboard_drained", sb_a.size(), 0);
        chk("b_scoreboard_drained", sb_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
